usfft64_result_collector: RTL and testbench

Output-side partner of the USFFT64 core: captures the 64 complex results the core emits (RDY / ADDR / DOR / DOI, qualified by ED) into a ping-pong buffer and replays each completed frame as a valid/ready stream in natural index order, with the frame's overflow flags attached. It sits between the core's output port group and the downstream consumer (host interface or test logic), so the core never stalls on back-pressure.

---
 rtl/usfft64_pkg.sv | 24 ++
 rtl/usfft64_rc_bank.sv | 34 +++
 rtl/usfft64_result_collector.sv | 251 +++++++++++++++++++++++++
 tb/tb_usfft64_result_collector.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usfft64_pkg.sv
// Shared definitions for the USFFT64 result collector: sizes, FSM state
// types and the packed bank word layout.
package usfft64_pkg;

    localparam int DW        = 19;
    localparam int AW        = 6;
    localparam int FRAME_LEN = 64;

    typedef enum logic {
        CAP_IDLE,
        CAP_CAPT
    } cap_state_t;

    typedef enum logic {
        D_IDLE,
        D_RUN
    } drn_state_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } bank_word_t;

endpackage

// File: rtl/usfft64_rc_bank.sv
// One frame bank: 2**AW words, single write port, single synchronous read
// port. The read register only updates when re is high, so a stalled
// consumer sees the last fetched word held.
module usfft64_rc_bank
    import usfft64_pkg::*;
#(
    parameter int W  = $bits(bank_word_t),
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_q;

    // Memory write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/usfft64_result_collector.sv
// Ping-pong frame collector behind the USFFT64 core: captures 64 indexed
// results per frame into one of two banks and replays full banks in index
// order as a valid/ready stream with the frame's sticky overflow flags.
module usfft64_result_collector
    import usfft64_pkg::*;
#(
    parameter int DW = 19,
    parameter int AW = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          RDY,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DOR,
    input  logic [DW-1:0] DOI,
    input  logic          OVF1,
    input  logic          OVF2,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [DW-1:0] M_DR,
    output logic [DW-1:0] M_DI,
    output logic [AW-1:0] M_INDEX,
    output logic          M_LAST,
    output logic [1:0]    M_OVF,
    output logic          DROP,
    output logic          FRAME_ERR,
    output logic [7:0]    DROP_CNT
);

    // capture side
    cap_state_t      cap_q, cap_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic            wb_q, wb_d;
    logic [1:0]      sovf_q, sovf_d;
    logic [1:0]      full_q, full_d;
    logic [1:0][1:0] bovf_q, bovf_d;
    logic            drop_q, drop_d;
    logic            ferr_q, ferr_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            we;
    logic            cap_done;

    // drain side
    drn_state_t      drn_q, drn_d;
    logic            rb_q, rb_d;
    logic [AW:0]     icnt_q, icnt_d;
    logic            issue;
    logic            advance;
    logic            hs_last;
    logic [AW-1:0]   raddr;
    logic            s1_valid_q, s1_valid_d;
    logic [AW-1:0]   s1_idx_q, s1_idx_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_dr_q, m_dr_d;
    logic [DW-1:0]   m_di_q, m_di_d;
    logic [AW-1:0]   m_index_q, m_index_d;
    logic            m_last_q, m_last_d;
    logic [1:0]      m_ovf_q, m_ovf_d;
    logic [2*DW-1:0] rdata0, rdata1, rd_sel;

    usfft64_rc_bank #(.W(2*DW), .AW(AW)) u_bank0 (
        .clk   (CLK),
        .we    (we && !wb_q),
        .waddr (ADDR),
        .wdata ({DOR, DOI}),
        .re    (issue && !rb_q),
        .raddr (raddr),
        .rdata (rdata0)
    );

    usfft64_rc_bank #(.W(2*DW), .AW(AW)) u_bank1 (
        .clk   (CLK),
        .we    (we && wb_q),
        .waddr (ADDR),
        .wdata ({DOR, DOI}),
        .re    (issue && rb_q),
        .raddr (raddr),
        .rdata (rdata1)
    );

    assign rd_sel = rb_q ? rdata1 : rdata0;

    // Capture FSM: bank write enable, write count, sticky flags, DROP/FRAME_ERR
    always_comb begin
        cap_d      = cap_q;
        wcnt_d     = wcnt_q;
        wb_d       = wb_q;
        sovf_d     = sovf_q;
        drop_d     = 1'b0;
        ferr_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        we         = 1'b0;
        cap_done   = 1'b0;
        if (cap_q == CAP_IDLE) begin
            if (ED && RDY) begin
                if (!full_q[wb_q]) begin
                    we     = 1'b1;
                    wcnt_d = AW'(1);
                    sovf_d = {OVF2, OVF1};
                    cap_d  = CAP_CAPT;
                end else begin
                    drop_d = 1'b1;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end
        end else if (ED) begin
            we = 1'b1;
            if (RDY) begin
                ferr_d = 1'b1;
                wcnt_d = AW'(1);
                sovf_d = {OVF2, OVF1};
            end else begin
                wcnt_d = wcnt_q + AW'(1);
                sovf_d = sovf_q | {OVF2, OVF1};
                if (wcnt_q == '1) begin
                    cap_done = 1'b1;
                    wcnt_d   = '0;
                    wb_d     = ~wb_q;
                    cap_d    = CAP_IDLE;
                end
            end
        end
    end

    // Drain FSM: issues reads 0..63 from bank RB whenever the pipe can move
    always_comb begin
        advance = !m_valid_q || M_READY;
        hs_last = m_valid_q && M_READY && m_last_q;
        issue   = 1'b0;
        raddr   = icnt_q[AW-1:0];
        drn_d   = drn_q;
        icnt_d  = icnt_q;
        rb_d    = rb_q;
        if (drn_q == D_IDLE) begin
            if (full_q[rb_q] && advance) begin
                issue  = 1'b1;
                raddr  = '0;
                icnt_d = (AW+1)'(1);
                drn_d  = D_RUN;
            end
        end else begin
            if (advance && !icnt_q[AW]) begin
                issue  = 1'b1;
                icnt_d = icnt_q + (AW+1)'(1);
            end
            if (hs_last) begin
                rb_d   = ~rb_q;
                icnt_d = '0;
                drn_d  = D_IDLE;
            end
        end
    end

    // Bank FULL/OVF bookkeeping; capture and drain always touch different banks
    always_comb begin
        full_d = full_q;
        bovf_d = bovf_q;
        if (cap_done) begin
            full_d[wb_q] = 1'b1;
            bovf_d[wb_q] = sovf_d;
        end
        if (hs_last) begin
            full_d[rb_q] = 1'b0;
        end
    end

    // Read-stage tag and output register; both move together on advance
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_idx_d   = s1_idx_q;
        m_valid_d  = m_valid_q;
        m_dr_d     = m_dr_q;
        m_di_d     = m_di_q;
        m_index_d  = m_index_q;
        m_last_d   = m_last_q;
        m_ovf_d    = m_ovf_q;
        if (advance) begin
            s1_valid_d = issue;
            s1_idx_d   = raddr;
            m_valid_d  = s1_valid_q;
            if (s1_valid_q) begin
                m_dr_d    = rd_sel[2*DW-1:DW];
                m_di_d    = rd_sel[DW-1:0];
                m_index_d = s1_idx_q;
                m_last_d  = (s1_idx_q == '1);
                m_ovf_d   = bovf_q[rb_q];
            end
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cap_q      <= CAP_IDLE;
            wcnt_q     <= '0;
            wb_q       <= 1'b0;
            sovf_q     <= '0;
            full_q     <= '0;
            bovf_q     <= '0;
            drop_q     <= 1'b0;
            ferr_q     <= 1'b0;
            drop_cnt_q <= '0;
            drn_q      <= D_IDLE;
            rb_q       <= 1'b0;
            icnt_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            m_valid_q  <= 1'b0;
            m_dr_q     <= '0;
            m_di_q     <= '0;
            m_index_q  <= '0;
            m_last_q   <= 1'b0;
            m_ovf_q    <= '0;
        end else begin
            cap_q      <= cap_d;
            wcnt_q     <= wcnt_d;
            wb_q       <= wb_d;
            sovf_q     <= sovf_d;
            full_q     <= full_d;
            bovf_q     <= bovf_d;
            drop_q     <= drop_d;
            ferr_q     <= ferr_d;
            drop_cnt_q <= drop_cnt_d;
            drn_q      <= drn_d;
            rb_q       <= rb_d;
            icnt_q     <= icnt_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            m_valid_q  <= m_valid_d;
            m_dr_q     <= m_dr_d;
            m_di_q     <= m_di_d;
            m_index_q  <= m_index_d;
            m_last_q   <= m_last_d;
            m_ovf_q    <= m_ovf_d;
        end
    end

    assign M_VALID   = m_valid_q;
    assign M_DR      = m_dr_q;
    assign M_DI      = m_di_q;
    assign M_INDEX   = m_index_q;
    assign M_LAST    = m_last_q;
    assign M_OVF     = m_ovf_q;
    assign DROP      = drop_q;
    assign FRAME_ERR = ferr_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_usfft64_result_collector.sv
// Scoreboard bench for usfft64_result_collector: frames are driven with
// directed data, expected stream words are queued when a frame completes,
// and a negedge monitor pops and compares on every handshake.
module tb_usfft64_result_collector;

    localparam int DW = 19;
    localparam int AW = 6;

    typedef struct packed {
        logic [DW-1:0] dr;
        logic [DW-1:0] di;
        logic [AW-1:0] idx;
        logic          last;
        logic [1:0]    ovf;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ED = 1'b0;
    logic          RDY = 1'b0;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] DOR = '0;
    logic [DW-1:0] DOI = '0;
    logic          OVF1 = 1'b0;
    logic          OVF2 = 1'b0;
    logic          M_VALID;
    logic          M_READY = 1'b1;
    logic [DW-1:0] M_DR;
    logic [DW-1:0] M_DI;
    logic [AW-1:0] M_INDEX;
    logic          M_LAST;
    logic [1:0]    M_OVF;
    logic          DROP;
    logic          FRAME_ERR;
    logic [7:0]    DROP_CNT;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ndrop = 0;
    int   nferr = 0;
    exp_t q[$];

    usfft64_result_collector #(.DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ED        (ED),
        .RDY       (RDY),
        .ADDR      (ADDR),
        .DOR       (DOR),
        .DOI       (DOI),
        .OVF1      (OVF1),
        .OVF2      (OVF2),
        .M_VALID   (M_VALID),
        .M_READY   (M_READY),
        .M_DR      (M_DR),
        .M_DI      (M_DI),
        .M_INDEX   (M_INDEX),
        .M_LAST    (M_LAST),
        .M_OVF     (M_OVF),
        .DROP      (DROP),
        .FRAME_ERR (FRAME_ERR),
        .DROP_CNT  (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] word_re(input int seed, input int idx);
        return DW'(idx + seed * 100);
    endfunction

    function automatic logic [AW-1:0] brev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: stall-hold check and scoreboard compare on each handshake
    logic          hold_pend = 1'b0;
    logic [47:0]   hold_v;
    always @(negedge CLK) begin
        if (RST) begin
            if (hold_pend) begin
                tests++;
                if (!(M_VALID && {M_DR, M_DI, M_INDEX, M_LAST, M_OVF} == hold_v)) begin
                    fails++;
                    $display("FAIL stall_hold got valid=%b word=%h expected valid=1 word=%h",
                             M_VALID, {M_DR, M_DI, M_INDEX, M_LAST, M_OVF}, hold_v);
                end
            end
            if (M_VALID && M_READY) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out got idx=%0d dr=%h expected no output", M_INDEX, M_DR);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({M_DR, M_DI, M_INDEX, M_LAST, M_OVF} !== e) begin
                        fails++;
                        $display("FAIL out_word got idx=%0d dr=%h di=%h last=%b ovf=%b expected idx=%0d dr=%h di=%h last=%b ovf=%b",
                                 M_INDEX, M_DR, M_DI, M_LAST, M_OVF, e.idx, e.dr, e.di, e.last, e.ovf);
                    end
                end
            end
            hold_pend = M_VALID && !M_READY;
            hold_v    = {M_DR, M_DI, M_INDEX, M_LAST, M_OVF};
            if (DROP) ndrop++;
            if (FRAME_ERR) nferr++;
        end else begin
            hold_pend = 1'b0;
        end
    end

    // Drive nsamp samples as one frame; RDY on sample 0, pulses checked one cycle later
    task automatic send_frame(input int seed, input bit rev, input int ovf_at, input int nsamp,
                              input bit exp_drop, input bit exp_ferr, input bit push);
        logic [1:0]    eo;
        logic [AW-1:0] a;
        logic [DW-1:0] t;
        exp_t          e;
        eo = 2'b00;
        for (int i = 0; i < nsamp; i++) begin
            @(posedge CLK); #1;
            a    = rev ? brev(AW'(i)) : AW'(i);
            t    = word_re(seed, int'(a));
            ED   = 1'b1;
            RDY  = (i == 0);
            ADDR = a;
            DOR  = t;
            DOI  = -t;
            OVF1 = (i == ovf_at);
            OVF2 = 1'b0;
            if (i == ovf_at) eo[0] = 1'b1;
            if (i == 1) begin
                @(negedge CLK);
                chk("drop_pulse", 64'(DROP), 64'(exp_drop));
                chk("frame_err_pulse", 64'(FRAME_ERR), 64'(exp_ferr));
            end
        end
        @(posedge CLK); #1;
        ED = 1'b0; RDY = 1'b0; OVF1 = 1'b0;
        if (push) begin
            for (int k = 0; k < 64; k++) begin
                e.dr   = word_re(seed, k);
                e.di   = -word_re(seed, k);
                e.idx  = AW'(k);
                e.last = (k == 63);
                e.ovf  = eo;
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            if (q.size() == 0 && !M_VALID) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_complete", 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs();
        chk("reset_outputs",
            64'({M_VALID, M_DR, M_DI, M_INDEX, M_LAST, M_OVF, DROP, FRAME_ERR, DROP_CNT}), 64'd0);
    endtask

    initial begin
        int start;
        int lat;
        bit found;

        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        // natural order frame, latency of first valid
        send_frame(0, 1'b0, -1, 64, 1'b0, 1'b0, 1'b1);
        start = cyc;
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (M_VALID) begin
                lat = cyc - start;
                break;
            end
        end
        chk("first_valid_latency", 64'(lat), 64'd2);
        wait_drain();

        // bit-reversed capture order
        send_frame(1, 1'b1, -1, 64, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // overflow in frame A only, clean frame B
        send_frame(2, 1'b0, 10, 64, 1'b0, 1'b0, 1'b1);
        send_frame(7, 1'b0, -1, 64, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // consumer stalled across three frames: third is dropped
        M_READY = 1'b0;
        send_frame(8, 1'b0, -1, 64, 1'b0, 1'b0, 1'b1);
        send_frame(9, 1'b1, -1, 64, 1'b0, 1'b0, 1'b1);
        send_frame(10, 1'b0, -1, 64, 1'b1, 1'b0, 1'b0);
        chk("drop_cnt", 64'(DROP_CNT), 64'd1);
        repeat (5) @(posedge CLK);
        #1;
        M_READY = 1'b1;
        wait_drain();

        // RDY again after 30 samples restarts the frame
        send_frame(3, 1'b0, -1, 30, 1'b0, 1'b0, 1'b0);
        send_frame(4, 1'b0, -1, 64, 1'b0, 1'b1, 1'b1);
        wait_drain();

        // reset while draining index 20
        send_frame(5, 1'b0, -1, 64, 1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge CLK); #1;
            if (M_VALID && M_INDEX == AW'(20)) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_index20", 64'(found), 64'd1);
        RST = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        @(posedge CLK); #1;
        check_reset_outputs();
        RST = 1'b1;
        send_frame(6, 1'b0, -1, 64, 1'b0, 1'b0, 1'b1);
        wait_drain();

        chk("total_drop_pulses", 64'(ndrop), 64'd1);
        chk("total_frame_err_pulses", 64'(nferr), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
